// File: rtl/shell_pkg.sv
// Shared constants for the shell dispatcher: command-name table, built-in
// messages, FSM encoding and a ROM lookup helper for the message streamer.
package shell_pkg;

  localparam int LINE_MAX     = 32;
  localparam int CMD_NAME_LEN = 8;

  // Names are left-aligned and zero-padded; char j lives at [63-8j -: 8].
  localparam logic [63:0] CMD_NAME [8] = '{
    {"help",  32'h0},
    {"ls",    48'h0},
    {"echo",  32'h0},
    {"cat",   40'h0},
    {"date",  32'h0},
    {"clear", 24'h0},
    {"uname", 24'h0},
    {"shutdown"}
  };

  localparam int ERR_LEN = 18;
  localparam int TMO_LEN = 9;
  localparam logic [8*ERR_LEN-1:0] ERR_MSG = {"command not found", 8'h00};
  // Leading NUL terminates whatever partial line the executor left behind.
  localparam logic [8*TMO_LEN-1:0] TMO_MSG = {8'h00, "timeout", 8'h00};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MATCH,
    S_RUN,
    S_MSG,
    S_SOLVE,
    S_WAIT_ACK
  } state_t;

  function automatic logic [7:0] msg_byte(input logic sel, input logic [4:0] idx);
    logic [7:0] b;
    b = 8'h00;
    if (sel) begin
      if (int'(idx) < TMO_LEN) b = TMO_MSG[8*(TMO_LEN-1-int'(idx)) +: 8];
    end else begin
      if (int'(idx) < ERR_LEN) b = ERR_MSG[8*(ERR_LEN-1-int'(idx)) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/shell_msg_streamer.sv
// Streams one of the built-in ROM messages (sel 0 = error, 1 = timeout) over
// the terminal bash-input handshake; done pulses as the final byte is taken.
module shell_msg_streamer
  import shell_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic       next,
  output logic       valid,
  output logic [7:0] msg_char,
  output logic       done
);

  logic [4:0] ptr_q, ptr_d;
  logic       active_q, active_d;
  logic       sel_q, sel_d;
  logic [4:0] last;

  assign last     = sel_q ? 5'(TMO_LEN - 1) : 5'(ERR_LEN - 1);
  assign valid    = active_q;
  assign msg_char = active_q ? msg_byte(sel_q, ptr_q) : 8'h00;

  always_comb begin
    ptr_d    = ptr_q;
    active_d = active_q;
    sel_d    = sel_q;
    done     = 1'b0;
    if (start) begin
      ptr_d    = '0;
      active_d = 1'b1;
      sel_d    = sel;
    end else if (active_q && next) begin
      if (ptr_q == last) begin
        active_d = 1'b0;
        done     = 1'b1;
      end else begin
        ptr_d = ptr_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= '0;
      active_q <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      active_q <= active_d;
      sel_q    <= sel_d;
    end
  end

endmodule

// File: rtl/shell_dispatcher.sv
// Drains a terminal line, matches its first token against the command table,
// runs one executor and relays its response, or emits a built-in message.
module shell_dispatcher
  import shell_pkg::*;
#(
  parameter int N_CMD          = 4,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               term_out_ready,
  input  logic [5:0]         term_out_len,
  input  logic [7:0]         term_out_char,
  output logic               term_out_next,
  output logic               term_in_ready,
  output logic [7:0]         term_in_char,
  input  logic               term_in_next,
  output logic               term_solved,
  input  logic               term_solved_ack,
  output logic [N_CMD-1:0]   cmd_start,
  output logic [N_CMD-1:0]   cmd_abort,
  input  logic [4:0]         cmd_arg_addr,
  output logic [7:0]         cmd_arg_data,
  output logic [5:0]         cmd_arg_len,
  input  logic [N_CMD-1:0]   resp_valid,
  input  logic [8*N_CMD-1:0] resp_char,
  output logic [N_CMD-1:0]   resp_ready,
  input  logic [N_CMD-1:0]   resp_done
);

  localparam int AW = (N_CMD > 1) ? $clog2(N_CMD) : 1;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d, len_q, len_d;
  logic            phase_q, phase_d;
  logic            out_next_q, out_next_d;
  logic [AW-1:0]   idx_q, idx_d, act_q, act_d;
  logic            done_flag_q, done_flag_d;
  logic [31:0]     timer_q, timer_d;
  logic [7:0]      buf_q [LINE_MAX];
  logic            buf_we;
  logic [5:0]      k, arg_start;
  logic [4:0]      arg_idx;
  logic [63:0]     name;
  logic            hit;
  logic            msg_start, msg_sel, msg_next, msg_valid, msg_done;
  logic [7:0]      msg_char;

  assign term_out_next = out_next_q;

  // Token length: position of the first space, else the whole line.
  always_comb begin
    k = len_q;
    for (int j = LINE_MAX - 1; j >= 0; j--) begin
      if (6'(j) < len_q && buf_q[j] == 8'h20) k = 6'(j);
    end
  end

  assign arg_start    = (k < len_q) ? k + 6'd1 : len_q;
  assign cmd_arg_len  = len_q - arg_start;
  assign arg_idx      = arg_start[4:0] + cmd_arg_addr;
  assign cmd_arg_data = ({1'b0, cmd_arg_addr} < cmd_arg_len) ? buf_q[arg_idx] : 8'h00;

  always_comb begin
    name = '0;
    for (int i = 0; i < N_CMD; i++) begin
      if (idx_q == AW'(i)) name = CMD_NAME[i];
    end
    hit = (k <= 6'd8);
    for (int j = 0; j < CMD_NAME_LEN; j++) begin
      if (6'(j) < k && name[8*(7-j) +: 8] != buf_q[j]) hit = 1'b0;
      if (6'(j) == k && name[8*(7-j) +: 8] != 8'h00) hit = 1'b0;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    phase_d       = phase_q;
    out_next_d    = 1'b0;
    idx_d         = idx_q;
    act_d         = act_q;
    done_flag_d   = done_flag_q;
    timer_d       = timer_q;
    buf_we        = 1'b0;
    msg_start     = 1'b0;
    msg_sel       = 1'b0;
    cmd_start     = '0;
    cmd_abort     = '0;
    resp_ready    = '0;
    term_in_ready = 1'b0;
    term_in_char  = 8'h00;
    term_solved   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (term_out_ready) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
          phase_d = 1'b0;
          len_d   = term_out_len;
        end
      end
      S_CAPTURE: begin
        if (!phase_q) begin
          if (cnt_q == len_q) begin
            state_d = (len_q == 6'd0) ? S_SOLVE : S_MATCH;
            idx_d   = '0;
          end else begin
            buf_we     = 1'b1;
            out_next_d = 1'b1;
            cnt_d      = cnt_q + 6'd1;
            phase_d    = 1'b1;
          end
        end else begin
          phase_d = 1'b0;
        end
      end
      S_MATCH: begin
        if (hit) begin
          cmd_start[idx_q] = 1'b1;
          act_d            = idx_q;
          done_flag_d      = 1'b0;
          timer_d          = '0;
          state_d          = S_RUN;
        end else if (idx_q == AW'(N_CMD - 1)) begin
          msg_start = 1'b1;
          state_d   = S_MSG;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_RUN: begin
        term_in_ready      = resp_valid[act_q];
        term_in_char       = resp_char[8*act_q +: 8];
        resp_ready[act_q]  = term_in_next;
        if (resp_done[act_q]) done_flag_d = 1'b1;
        if (term_in_next) timer_d = '0;
        else if (timer_q != '1) timer_d = timer_q + 32'd1;
        // A char still pending after done is delivered before finishing.
        if (done_flag_q && !resp_valid[act_q] && !term_in_next) begin
          state_d = S_SOLVE;
        end else if (!term_in_next && timer_q >= 32'(TIMEOUT_CYCLES - 1)) begin
          cmd_abort[act_q] = 1'b1;
          msg_start        = 1'b1;
          msg_sel          = 1'b1;
          state_d          = S_MSG;
        end
      end
      S_MSG: begin
        term_in_ready = msg_valid;
        term_in_char  = msg_char;
        if (msg_done) state_d = S_SOLVE;
      end
      S_SOLVE: begin
        term_solved = 1'b1;
        state_d     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (term_solved_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign msg_next = term_in_next && (state_q == S_MSG);

  shell_msg_streamer u_msg (
    .clk      (clk),
    .rst      (rst),
    .start    (msg_start),
    .sel      (msg_sel),
    .next     (msg_next),
    .valid    (msg_valid),
    .msg_char (msg_char),
    .done     (msg_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      phase_q     <= 1'b0;
      out_next_q  <= 1'b0;
      idx_q       <= '0;
      act_q       <= '0;
      done_flag_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      phase_q     <= phase_d;
      out_next_q  <= out_next_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      done_flag_q <= done_flag_d;
      timer_q     <= timer_d;
    end
  end

  // Line buffer keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q[4:0]] <= term_out_char;
  end

endmodule

// File: tb/tb_shell_dispatcher.sv
// Directed bench for shell_dispatcher: terminal and executor are modelled
// inline; every expectation comes from the command table and message strings.
module tb_shell_dispatcher;

  logic        clk;
  logic        rst;
  logic        term_out_ready;
  logic [5:0]  term_out_len;
  logic [7:0]  term_out_char;
  logic        term_out_next;
  logic        term_in_ready;
  logic [7:0]  term_in_char;
  logic        term_in_next;
  logic        term_solved;
  logic        term_solved_ack;
  logic [3:0]  cmd_start;
  logic [3:0]  cmd_abort;
  logic [4:0]  cmd_arg_addr;
  logic [7:0]  cmd_arg_data;
  logic [5:0]  cmd_arg_len;
  logic [3:0]  resp_valid;
  logic [31:0] resp_char;
  logic [3:0]  resp_ready;
  logic [3:0]  resp_done;

  logic [63:0] outs;
  assign outs = {27'b0, term_out_next, term_in_ready, term_in_char, term_solved,
                 cmd_start, cmd_abort, cmd_arg_data, cmd_arg_len, resp_ready};

  shell_dispatcher #(.N_CMD(4), .TIMEOUT_CYCLES(100)) dut (
    .clk             (clk),
    .rst             (rst),
    .term_out_ready  (term_out_ready),
    .term_out_len    (term_out_len),
    .term_out_char   (term_out_char),
    .term_out_next   (term_out_next),
    .term_in_ready   (term_in_ready),
    .term_in_char    (term_in_char),
    .term_in_next    (term_in_next),
    .term_solved     (term_solved),
    .term_solved_ack (term_solved_ack),
    .cmd_start       (cmd_start),
    .cmd_abort       (cmd_abort),
    .cmd_arg_addr    (cmd_arg_addr),
    .cmd_arg_data    (cmd_arg_data),
    .cmd_arg_len     (cmd_arg_len),
    .resp_valid      (resp_valid),
    .resp_char       (resp_char),
    .resp_ready      (resp_ready),
    .resp_done       (resp_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  rx [64];
  int          rx_n, solved_n;
  logic [3:0]  rr_seen;
  bit          ex_on, ex_early;
  int          ex_id, ex_len;
  logic [7:0]  ex_bytes [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_line(input string s, input int stop, output int pulses);
    int ptr, n;
    n = s.len(); ptr = 0; pulses = 0;
    @(negedge clk);
    term_out_len   = 6'(n);
    term_out_char  = (n > 0) ? s[0] : 8'h00;
    term_out_ready = 1'b1;
    for (int c = 1; c <= 2*n+1 && c <= stop; c++) begin
      @(negedge clk);
      term_out_ready = 1'b0;
      if (term_out_next) begin
        pulses++; ptr++;
        term_out_char = (ptr < n) ? s[ptr] : 8'h00;
      end
    end
  endtask

  task automatic wait_start(input int budget, output logic [3:0] vec, output int cyc);
    vec = '0; cyc = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk); #1;
      if (cmd_start != 4'b0) begin vec = cmd_start; cyc = c; break; end
    end
  endtask

  task automatic set_ex(input int id, input string s, input bit early);
    ex_on = 1'b1; ex_id = id; ex_early = early; ex_len = s.len() + 1;
    for (int i = 0; i < s.len(); i++) ex_bytes[i] = s[i];
    ex_bytes[ex_len-1] = 8'h00;
  endtask

  // Acts as terminal (and executor when ex_on) until a few cycles past term_solved.
  task automatic recv(input int budget);
    int ptr, solved_at;
    bit done_sent;
    ptr = 0; done_sent = 1'b0; rx_n = 0; solved_n = 0; solved_at = -1; rr_seen = '0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (term_in_next && ex_on) ptr++;
      term_in_next = 1'b0;
      resp_done    = '0;
      if (ex_on) begin
        if (ptr < ex_len) begin
          resp_valid = 4'(1 << ex_id);
          resp_char  = 32'(ex_bytes[ptr]) << (8*ex_id);
        end else begin
          resp_valid = '0;
          resp_char  = '0;
        end
        if (!done_sent && (ptr >= ex_len || (ex_early && ptr == ex_len-1))) begin
          resp_done = 4'(1 << ex_id);
          done_sent = 1'b1;
        end
      end
      #1;
      if (term_solved) begin
        solved_n++;
        if (solved_at < 0) solved_at = c;
      end else if (term_in_ready && rx_n < 64) begin
        rx[rx_n] = term_in_char; rx_n++;
        term_in_next = 1'b1;
        #1 rr_seen = rr_seen | resp_ready;
      end
      if (solved_at >= 0 && c >= solved_at + 3) break;
    end
    term_in_next = 1'b0; resp_valid = '0; resp_done = '0; resp_char = '0; ex_on = 1'b0;
  endtask

  task automatic chk_rx(input string tag, input string s, input bit lead);
    int n;
    logic [7:0] e;
    n = s.len() + 1 + (lead ? 1 : 0);
    chk({tag, " len"}, 64'(rx_n), 64'(n));
    for (int j = 0; j < n; j++) begin
      if (lead && j == 0) e = 8'h00;
      else if (j == n-1) e = 8'h00;
      else e = s[lead ? j-1 : j];
      chk($sformatf("%s byte %0d", tag, j), rx[j], e);
    end
  endtask

  task automatic ack();
    @(negedge clk); term_solved_ack = 1'b1;
    @(negedge clk); term_solved_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, cyc, ab_cyc;
    logic [3:0] v, ab_vec;
    rst = 1'b1; term_out_ready = 0; term_out_len = 0; term_out_char = 0;
    term_in_next = 0; term_solved_ack = 0; cmd_arg_addr = 0;
    resp_valid = 0; resp_char = 0; resp_done = 0; ex_on = 0; ex_early = 0;
    ex_id = 0; ex_len = 0;
    repeat (3) @(negedge clk);
    #1 chk("reset outputs", outs, 64'h0);
    rst = 1'b0;

    // "ls -a": executor 1, argument "-a", response "ok"
    send_line("ls -a", 99, p);
    chk("ls-a next pulses", 64'(p), 64'd5);
    wait_start(6, v, cyc);
    chk("ls-a start", v, 4'b0010);
    chk("ls-a latency", 64'(cyc), 64'd2);
    chk("ls-a arg_len", cmd_arg_len, 6'd2);
    cmd_arg_addr = 5'd0; #1 chk("ls-a arg0", cmd_arg_data, 8'h2D);
    cmd_arg_addr = 5'd1; #1 chk("ls-a arg1", cmd_arg_data, 8'h61);
    cmd_arg_addr = 5'd2; #1 chk("ls-a arg2", cmd_arg_data, 8'h00);
    cmd_arg_addr = 5'd0;
    set_ex(1, "ok", 1'b0);
    recv(40);
    chk_rx("ls-a resp", "ok", 1'b0);
    chk("ls-a solved pulses", 64'(solved_n), 64'd1);
    chk("ls-a resp_ready", rr_seen, 4'b0010);
    ack();

    // "ls" with no args; done arrives while the last char is still pending
    send_line("ls", 99, p);
    wait_start(6, v, cyc);
    chk("ls start", v, 4'b0010);
    chk("ls arg_len", cmd_arg_len, 6'd0);
    #1 chk("ls arg0", cmd_arg_data, 8'h00);
    set_ex(1, "a", 1'b1);
    recv(40);
    chk_rx("ls resp", "a", 1'b0);
    chk("ls solved pulses", 64'(solved_n), 64'd1);
    ack();

    // unknown command
    send_line("foo", 99, p);
    wait_start(4, v, cyc);
    chk("foo start", v, 4'b0000);
    recv(60);
    chk_rx("foo err", "command not found", 1'b0);
    chk("foo solved pulses", 64'(solved_n), 64'd1);
    ack();

    // token longer than a table name is not a prefix match
    send_line("lsx", 99, p);
    wait_start(4, v, cyc);
    chk("lsx start", v, 4'b0000);
    recv(60);
    chk("lsx err len", 64'(rx_n), 64'd18);
    chk("lsx solved pulses", 64'(solved_n), 64'd1);
    ack();

    // empty line
    send_line("", 99, p);
    chk("empty next pulses", 64'(p), 64'd0);
    cyc = -1; v = '0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); #1;
      v = v | cmd_start;
      if (term_solved) begin cyc = c; break; end
    end
    chk("empty solved cycle", 64'(cyc), 64'd1);
    chk("empty start", v, 4'b0000);
    ack();

    // silent executor times out
    send_line("echo hi", 99, p);
    wait_start(6, v, cyc);
    chk("echo start", v, 4'b0100);
    chk("echo latency", 64'(cyc), 64'd3);
    chk("echo arg_len", cmd_arg_len, 6'd2);
    ab_cyc = -1; ab_vec = '0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk); #1;
      if (cmd_abort != 4'b0) begin ab_cyc = c; ab_vec = cmd_abort; break; end
    end
    chk("echo abort cycle", 64'(ab_cyc), 64'd100);
    chk("echo abort vec", ab_vec, 4'b0100);
    recv(40);
    chk_rx("echo tmo", "timeout", 1'b1);
    chk("echo solved pulses", 64'(solved_n), 64'd1);
    ack();

    // reset during CAPTURE, while term_out_next is high
    send_line("cat x", 4, p);
    chk("cap next pulses", 64'(p), 64'd2);
    chk("cap next high", term_out_next, 1'b1);
    rst = 1'b1;
    #1 chk("cap reset outputs", outs, 64'h0);
    @(negedge clk); rst = 1'b0; term_out_ready = 1'b0;

    // reset during RUN with a char on offer
    send_line("ls", 99, p);
    wait_start(6, v, cyc);
    chk("run start", v, 4'b0010);
    @(negedge clk);
    resp_valid = 4'b0010; resp_char = 32'h0000_7A00;
    #1 chk("run ready", term_in_ready, 1'b1);
    chk("run char", term_in_char, 8'h7A);
    rst = 1'b1;
    #1 chk("run reset outputs", outs, 64'h0);
    @(negedge clk); rst = 1'b0; resp_valid = '0; resp_char = '0;

    // next line after reset runs normally
    send_line("help", 99, p);
    wait_start(6, v, cyc);
    chk("help start", v, 4'b0001);
    chk("help latency", 64'(cyc), 64'd1);
    set_ex(0, "hi", 1'b0);
    recv(40);
    chk_rx("help resp", "hi", 1'b0);
    chk("help solved pulses", 64'(solved_n), 64'd1);
    chk("help resp_ready", rr_seen, 4'b0001);
    ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shell_dispatcher.md
# shell_dispatcher

Command scheduler between the terminal video-memory block and up to `N_CMD` command executors. It drains each entered line from the terminal's bash-output handshake, matches the first token against a command-name table, and starts exactly one executor. It streams that executor's response back through the terminal's bash-input handshake, then signals completion so keyboard input resumes. Unknown commands and timed-out executors produce built-in messages.

## Interface
Parameters:
- `N_CMD`, 4: number of executors, 1–8.
- `TIMEOUT_CYCLES`, 50_000_000: idle cycles allowed in RUN before abort.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1: system clock.
- `rst` in 1: async active-high reset.
- `term_out_ready` in 1: terminal has a line (out_newASCII_ready).
- `term_out_len` in 6: line length, 0–32.
- `term_out_char` in 8: current line char.
- `term_out_next` out 1: one-cycle pulse, advance terminal line pointer.
- `term_in_ready` out 1: response char valid toward terminal.
- `term_in_char` out 8: response char; 0 = end of line.
- `term_in_next` in 1: terminal consumed char (lineIn_nextASCII).
- `term_solved` out 1: one-cycle command-finished pulse.
- `term_solved_ack` in 1: terminal acknowledged (out_solved).
- `cmd_start` out N_CMD: one-hot one-cycle start pulse.
- `cmd_abort` out N_CMD: one-hot one-cycle abort pulse.
- `cmd_arg_addr` in 5: argument read address.
- `cmd_arg_data` out 8: argument byte; 0 if addr ≥ arg_len.
- `cmd_arg_len` out 6: argument length.
- `resp_valid` in N_CMD: executor i has a char.
- `resp_char` in 8·N_CMD: executor i char, slice [8i+7:8i].
- `resp_ready` out N_CMD: char consumed by the terminal.
- `resp_done` in N_CMD: executor i finished, one-cycle pulse.

## Operation
- States: IDLE, CAPTURE, MATCH, RUN, MSG, SOLVE, WAIT_ACK.
- IDLE: when `term_out_ready` is high → CAPTURE with cnt=0.
- CAPTURE alternates two cycles per char:
  - Cycle A: if cnt==len → MATCH. Otherwise `buf[cnt]<=term_out_char`, `term_out_next<=1`, cnt++.
  - Cycle B: `term_out_next<=0`.
  - Len 0 goes directly to SOLVE.
- Token length k = index of the first 0x20 in buf, else len.
- MATCH: one table entry per cycle, i = 0..N_CMD-1, 8 chars compared in parallel.
  - Hit when k≤8, `CMD_NAME[i][0..k-1]` equals the token, and the name is 0-padded at k (or k==8).
  - Lowest i wins. On hit, pulse `cmd_start[i]` → RUN. No hit after N_CMD cycles → MSG with ERR_MSG.
- Arguments: arg_start = min(k+1, len); `cmd_arg_len = len-arg_start`; `cmd_arg_data` = buf[arg_start+addr] (combinational). Stable from the start pulse until IDLE.
- RUN with active executor a:
  - `term_in_ready = resp_valid[a]`, `term_in_char = resp_char[a]`.
  - `resp_ready[a] = term_in_next` (combinational). The executor must present its next char/valid on the edge where `resp_ready` is high.
  - `resp_done[a]` sets `done_flag`. Go to SOLVE when `done_flag` is set and `resp_valid[a]`, `term_in_next` are both low; a pending char is streamed first.
- Timeout: counter clears on start and on each `term_in_next`. When it reaches TIMEOUT_CYCLES: pulse `cmd_abort[a]` → MSG with TMO_MSG.
- MSG: streams a ROM string with the same handshake; pointer advances on `term_in_next`. The final 0 byte is sent, then → SOLVE.
- SOLVE: `term_solved=1` for one cycle → WAIT_ACK. On `term_solved_ack` → IDLE.
- Non-selected `resp_*` inputs are ignored. A `term_out_ready` seen outside IDLE is ignored.

## Timing
- Reset value of every output is 0. State → IDLE, counters 0; buf is not cleared.
- Reset mid-operation returns to IDLE without pulsing `cmd_abort`.
- Line drain: 2·len+1 cycles. Match latency: i+1 cycles to the hit, N_CMD for a miss.
- `term_in_ready` falls in the same cycle `resp_valid` falls; no registered stage.
- Timeout counter is ≥26 bits and saturates; it has no wrap-around.
- Simultaneous `resp_done` and a pending char: the char is delivered before `term_solved`.

## Structure
- Shared package `shell_pkg` holds:
  - `LINE_MAX=32`, `CMD_NAME_LEN=8`.
  - `CMD_NAME` table, 8 entries.
  - `ERR_MSG` = "command not found\0".
  - `TMO_MSG` = "\0timeout\0". The leading 0 ends any partial line.
  - State encoding.
- Sub-module `shell_msg_streamer`: ROM string pointer plus handshake, reused for both messages.

## Test plan
- Command "ls -a": `CMD_NAME[1]`="ls" → `cmd_start`=0b0010, `cmd_arg_len`=2. Reads at addr 0/1/2 return 0x2D/0x61/0x00.
- Executor 1 returns "ok\0" then `resp_done` → terminal receives 0x6F, 0x6B, 0x00. `term_solved` pulses once; state returns to IDLE on `term_solved_ack`.
- Command "foo" → no start. Exactly the 18 bytes of ERR_MSG are streamed, then `term_solved`.
- Empty line (len 0) → no `term_out_next`, no start, `term_solved` within 3 cycles.
- Executor silent with TIMEOUT_CYCLES=100 → `cmd_abort[a]` at cycle 100 after start, then TMO_MSG, then solved.
- `rst` asserted during CAPTURE and RUN → all outputs 0 immediately; the next line is processed normally.
